mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the write-back mux.
- Turns load/store requests into a req/ready handshake on the data-memory bus, stalling upstream while a transaction is outstanding.
- Formats load data (byte/half/word, signed/unsigned) into read_data for write-back.
- Passes ALU_result, MemtoReg, rd and RegWrite through to write-back, registered and aligned with the load data.

Parameters:
TIMEOUT_CYCLES, 16, maximum number of BUSY cycles waiting for dmem_ready before abort; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  EX/MEM holds a valid instruction
MemRead  input  1  load
MemWrite  input  1  store
funct3  input  3  access size/sign
ALU_result  input  32  effective address, or ALU value for non-memory instructions
store_data  input  32  rs2 value
rd  input  5  destination register
RegWrite  input  1  instruction writes rd
MemtoReg  input  1  write-back selects memory data
stall  output  1  upstream must hold all in_* signals
dmem_req  output  1  bus request
dmem_we  output  1  write enable
dmem_addr  output  32  word address {ALU_result[31:2],2'b00}
dmem_wdata  output  32  store data, replicated per size
dmem_wstrb  output  4  byte strobes
dmem_ready  input  1  memory completes the transaction this cycle
dmem_rdata  input  32  read word, valid when dmem_ready=1
wb_valid  output  1  write-back outputs valid this cycle
read_data  output  32  formatted load data
wb_ALU_result  output  32  registered ALU_result
wb_rd  output  5  registered rd
wb_RegWrite  output  1  registered RegWrite, gated by faults
wb_MemtoReg  output  1  registered MemtoReg
misaligned  output  1  misaligned access or illegal funct3; valid with wb_valid
bus_err  output  1  timeout abort; valid with wb_valid

Behaviour:
Reset:
- Synchronous reset: state=IDLE, timeout counter=0, every registered output=0.
- Reset mid-transaction drops dmem_req at that edge; no wb_valid is produced for the aborted instruction.

States: IDLE, BUSY.

Instruction classes:
- Non-memory instruction (in_valid, no MemRead/MemWrite) in IDLE:
  - wb_* registered next edge; wb_valid=1, read_data=0.
  - Latency 1 cycle; stall=0.
- Memory instruction in IDLE:
  - Address check: funct3 LB/LBU/SB(000/100) always aligned; LH/LHU/SH(001/101) need addr[0]=0; LW/SW(010) need addr[1:0]=00.
  - Any other funct3 is illegal.
- Misaligned or illegal access:
  - No bus access; next edge wb_valid=1, misaligned=1, wb_RegWrite=0.
  - stall=0.
- Aligned access:
  - Accept, go to BUSY; dmem_req/we/addr/wdata/wstrb registered at the accept edge.
  - stall=1 in the accept cycle.
- BUSY:
  - dmem_req held with stable we/addr/wdata/wstrb until the dmem_ready cycle.
  - in_* are ignored while BUSY.
  - stall = !dmem_ready && !timeout_hit.
- dmem_ready=1 in BUSY:
  - Next edge: dmem_req=0, state=IDLE, wb_valid=1 for one cycle.
  - Load: read_data formatted from dmem_rdata. Store: read_data=0.
- Load formatting: select the byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Store formatting:
  - SB: wdata={4{byte}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{half}}, wstrb=0011<<addr[1:0].
  - SW: wstrb=1111.
- Timeout:
  - Counter clears on accept and increments each BUSY cycle without ready.
  - If count reaches TIMEOUT_CYCLES-1 with no ready, next edge: dmem_req=0, IDLE, wb_valid=1, bus_err=1, wb_RegWrite=0.
  - dmem_ready on that same cycle wins: normal completion, no bus_err.
- Minimum load/store latency: accept edge → req cycle → ready → wb_valid, i.e. 2 cycles from accept when ready arrives in the first BUSY cycle.
- Back-to-back: a new instruction is accepted only in IDLE. The instruction presented after a completion is accepted in the cycle wb_valid is high.
- wb_valid=0 whenever no instruction completes; the other wb_* outputs hold their last values.

Test Plan:
- Reset then ALU op ALU_result=0x1234, rd=5, RegWrite=1 → next cycle wb_valid=1, wb_ALU_result=0x1234, wb_rd=5, stall=0.
- LB addr=0x103, dmem_rdata=0x80FF_0000, ready on first BUSY cycle → stall high 2 cycles, dmem_addr=0x100, read_data=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH addr=0x102, store_data=0xAAAA_BEEF → dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, wb_valid once after ready.
- LW addr=0x101 → no dmem_req, next cycle wb_valid=1, misaligned=1, wb_RegWrite=0.
- LW with dmem_ready never asserted, TIMEOUT_CYCLES=16 → dmem_req drops after 16 BUSY cycles, bus_err=1, wb_RegWrite=0, stall released.
- Reset asserted during BUSY (ready pending) → next edge dmem_req=0, wb_valid=0, IDLE; a subsequent SW completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Signal bundle for the memory-access stage: EX/MEM inputs, upstream stall,
// data-memory bus and write-back outputs. The stage is the bus master, so the
// stage binds to "master" and its environment (pipeline + memory) to "slave".
interface mem_access_stage_if;
    // EX/MEM side
    logic        in_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemtoReg;
    logic        stall;
    // Data-memory bus
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    // Write-back side
    logic        wb_valid;
    logic [31:0] read_data;
    logic [31:0] wb_ALU_result;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite;
    logic        wb_MemtoReg;
    logic        misaligned;
    logic        bus_err;

    modport master (
        input  in_valid, MemRead, MemWrite, funct3, ALU_result, store_data,
               rd, RegWrite, MemtoReg, dmem_ready, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, read_data, wb_ALU_result, wb_rd, wb_RegWrite,
               wb_MemtoReg, misaligned, bus_err
    );

    modport slave (
        output in_valid, MemRead, MemWrite, funct3, ALU_result, store_data,
               rd, RegWrite, MemtoReg, dmem_ready, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, read_data, wb_ALU_result, wb_rd, wb_RegWrite,
               wb_MemtoReg, misaligned, bus_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: converts loads/stores into a req/ready bus
// transaction, stalls upstream while one is outstanding, aborts on timeout,
// and presents formatted load data plus pass-through fields to write-back.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16   // 0 disables the timeout
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_stage_if.master  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Instruction captured at accept, used while BUSY and at completion
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [31:0]     r_alu;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic            r_memtoreg;

    // Bus and write-back registers
    logic            r_dmem_req, r_dmem_we;
    logic [31:0]     r_dmem_addr, r_dmem_wdata;
    logic [3:0]      r_dmem_wstrb;
    logic            r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
    logic [31:0]     r_read_data, r_wb_alu;
    logic [4:0]      r_wb_rd;
    logic            r_misaligned, r_bus_err;

    // Decode and control strobes
    logic            w_is_mem, w_legal, w_aligned, w_fault;
    logic [1:0]      w_size;
    logic            w_timeout_hit;
    logic            w_accept, w_fault_done, w_pass, w_complete, w_timeout, w_stall;
    logic [31:0]     w_wdata, w_load_data;
    logic [3:0]      w_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_is_mem  = bus.MemRead | bus.MemWrite;
    assign w_size    = bus.funct3[1:0];
    // Legal: 000/100 byte, 001/101 half, 010 word
    assign w_legal   = (w_size != 2'b11) && !(bus.funct3[2] && (w_size == 2'b10));
    assign w_aligned = (w_size == 2'b00) ||
                       ((w_size == 2'b01) && !bus.ALU_result[0]) ||
                       ((w_size == 2'b10) && (bus.ALU_result[1:0] == 2'b00));
    assign w_fault   = !(w_legal && w_aligned);

    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    // Next-state and handshake control
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fault_done = 1'b0;
        w_pass       = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!w_is_mem) begin
                        w_pass = 1'b1;
                    end else if (w_fault) begin
                        w_fault_done = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                // ready on the timeout cycle takes priority over the abort
                if (bus.dmem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (w_timeout_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Store data replication and byte strobes from size and address offset
    always_comb begin
        w_wdata = bus.store_data;
        w_wstrb = 4'b1111;
        case (w_size)
            2'b00: begin
                w_wdata = {4{bus.store_data[7:0]}};
                w_wstrb = 4'b0001 << bus.ALU_result[1:0];
            end
            2'b01: begin
                w_wdata = {2{bus.store_data[15:0]}};
                w_wstrb = 4'b0011 << bus.ALU_result[1:0];
            end
            default: ;
        endcase
    end

    // Load data selection and sign/zero extension
    always_comb begin
        w_byte = bus.dmem_rdata[8*r_off +: 8];
        w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = bus.dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Datapath: capture, bus request, timeout counter and write-back registers
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register here, so the stage restarts clean mid-transaction.
        if (!rst_n) begin
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_funct3      <= 3'd0;
            r_off         <= 2'd0;
            r_alu         <= 32'd0;
            r_rd          <= 5'd0;
            r_regwrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= 32'd0;
            r_dmem_wdata  <= 32'd0;
            r_dmem_wstrb  <= 4'd0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_read_data   <= 32'd0;
            r_wb_alu      <= 32'd0;
            r_wb_rd       <= 5'd0;
            r_misaligned  <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;

            if (r_state == BUSY && !bus.dmem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_cnt        <= '0;
                r_is_load    <= bus.MemRead;
                r_funct3     <= bus.funct3;
                r_off        <= bus.ALU_result[1:0];
                r_alu        <= bus.ALU_result;
                r_rd         <= bus.rd;
                r_regwrite   <= bus.RegWrite;
                r_memtoreg   <= bus.MemtoReg;
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= !bus.MemRead;
                r_dmem_addr  <= {bus.ALU_result[31:2], 2'b00};
                r_dmem_wdata <= bus.MemRead ? 32'd0 : w_wdata;
                r_dmem_wstrb <= bus.MemRead ? 4'd0 : w_wstrb;
            end

            if (w_pass || w_fault_done) begin
                r_wb_valid    <= 1'b1;
                r_wb_alu      <= bus.ALU_result;
                r_wb_rd       <= bus.rd;
                r_wb_regwrite <= bus.RegWrite && !w_fault_done;
                r_wb_memtoreg <= bus.MemtoReg;
                r_read_data   <= 32'd0;
                r_misaligned  <= w_fault_done;
                r_bus_err     <= 1'b0;
            end

            if (w_complete || w_timeout) begin
                r_dmem_req    <= 1'b0;
                r_wb_valid    <= 1'b1;
                r_wb_alu      <= r_alu;
                r_wb_rd       <= r_rd;
                r_wb_regwrite <= r_regwrite && w_complete;
                r_wb_memtoreg <= r_memtoreg;
                r_read_data   <= (w_complete && r_is_load) ? w_load_data : 32'd0;
                r_misaligned  <= 1'b0;
                r_bus_err     <= w_timeout;
            end
        end
    end

    assign bus.stall         = w_stall;
    assign bus.dmem_req      = r_dmem_req;
    assign bus.dmem_we       = r_dmem_we;
    assign bus.dmem_addr     = r_dmem_addr;
    assign bus.dmem_wdata    = r_dmem_wdata;
    assign bus.dmem_wstrb    = r_dmem_wstrb;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.read_data     = r_read_data;
    assign bus.wb_ALU_result = r_wb_alu;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_RegWrite   = r_wb_regwrite;
    assign bus.wb_MemtoReg   = r_wb_memtoreg;
    assign bus.misaligned    = r_misaligned;
    assign bus.bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: write-back results are predicted
// into a scoreboard queue at issue and compared whenever wb_valid is seen.
module tb_mem_access_stage;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    mem_access_stage_if u_if();

    mem_access_stage #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                            input logic m2r, input logic [31:0] rdata, input logic mis,
                            input logic berr);
        exp_t e;
        e.alu = alu; e.rd = rd; e.regwrite = rw; e.memtoreg = m2r;
        e.rdata = rdata; e.mis = mis; e.berr = berr;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw, input logic m2r);
        u_if.in_valid   = 1'b1;
        u_if.MemRead    = ld;
        u_if.MemWrite   = st;
        u_if.funct3     = f3;
        u_if.ALU_result = alu;
        u_if.store_data = sd;
        u_if.rd         = rd;
        u_if.RegWrite   = rw;
        u_if.MemtoReg   = m2r;
    endtask

    task automatic idle_in();
        u_if.in_valid = 1'b0;
        u_if.MemRead  = 1'b0;
        u_if.MemWrite = 1'b0;
    endtask

    // Non-memory instruction: one-cycle pass-through
    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        drive(1'b0, 1'b0, 3'b000, alu, 32'h0, rd, rw, 1'b0);
        push_exp(alu, rd, rw, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("alu_stall", u_if.stall, 0);
        @(negedge clk);
        idle_in();
        check("alu_no_req", u_if.dmem_req, 0);
    endtask

    // Misaligned or illegal load: no bus access, faulted write-back next cycle
    task automatic fault_op(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 1'b1, 1'b1);
        push_exp(addr, 5'd9, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        #1 check({tag, "_stall"}, u_if.stall, 0);
        @(negedge clk);
        idle_in();
        check({tag, "_no_req"}, u_if.dmem_req, 0);
    endtask

    // Aligned load/store with ready after 'waits' extra BUSY cycles
    task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input int waits,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata);
        drive(ld, !ld, f3, addr, sd, 5'd7, ld, ld);
        push_exp(addr, 5'd7, ld, ld, e_rdata, 1'b0, 1'b0);
        #1 check({tag, "_stall_acc"}, u_if.stall, 1);
        @(negedge clk);
        idle_in();
        for (int i = 0; i <= waits; i++) begin
            check({tag, "_req"}, u_if.dmem_req, 1);
            check({tag, "_we"}, u_if.dmem_we, {31'd0, !ld});
            check({tag, "_addr"}, u_if.dmem_addr, {addr[31:2], 2'b00});
            if (!ld) begin
                check({tag, "_wstrb"}, {28'd0, u_if.dmem_wstrb}, {28'd0, e_strb});
                check({tag, "_wdata"}, u_if.dmem_wdata, e_wdata);
            end
            check({tag, "_stall_busy"}, u_if.stall, 1);
            if (i < waits) @(negedge clk);
        end
        u_if.dmem_ready = 1'b1;
        u_if.dmem_rdata = rdata;
        #1 check({tag, "_stall_rdy"}, u_if.stall, 0);
        @(negedge clk);
        u_if.dmem_ready = 1'b0;
        u_if.dmem_rdata = 32'hDEAD_BEEF;
        check({tag, "_req_drop"}, u_if.dmem_req, 0);
    endtask

    // Scoreboard monitor: every wb_valid pulse must match the oldest prediction
    always @(negedge clk) begin
        if (u_if.wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_alu", u_if.wb_ALU_result, mon_e.alu);
                check("wb_rd", {27'd0, u_if.wb_rd}, {27'd0, mon_e.rd});
                check("wb_regwrite", {31'd0, u_if.wb_RegWrite}, {31'd0, mon_e.regwrite});
                check("wb_memtoreg", {31'd0, u_if.wb_MemtoReg}, {31'd0, mon_e.memtoreg});
                check("wb_read_data", u_if.read_data, mon_e.rdata);
                check("wb_misaligned", {31'd0, u_if.misaligned}, {31'd0, mon_e.mis});
                check("wb_bus_err", {31'd0, u_if.bus_err}, {31'd0, mon_e.berr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        u_if.in_valid   = 1'b0;
        u_if.MemRead    = 1'b0;
        u_if.MemWrite   = 1'b0;
        u_if.funct3     = 3'd0;
        u_if.ALU_result = 32'd0;
        u_if.store_data = 32'd0;
        u_if.rd         = 5'd0;
        u_if.RegWrite   = 1'b0;
        u_if.MemtoReg   = 1'b0;
        u_if.dmem_ready = 1'b0;
        u_if.dmem_rdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stall", u_if.stall, 0);
        check("rst_req", u_if.dmem_req, 0);
        check("rst_wb_valid", u_if.wb_valid, 0);
        check("rst_wb_alu", u_if.wb_ALU_result, 0);
        check("rst_read_data", u_if.read_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        alu_op(32'h0000_1234, 5'd5, 1'b1);
        @(negedge clk);

        // Loads; LBU issued in the cycle the LB write-back is presented
        mem_op("lb",  1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 4'h0, 32'h0, 32'h0000_0080);
        mem_op("lh",  1'b1, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 4'h0, 32'h0, 32'hFFFF_8001);
        mem_op("lhu", 1'b1, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0, 4'h0, 32'h0, 32'h0000_8001);
        mem_op("lw",  1'b1, 3'b010, 32'h104, 32'h0, 32'h1234_5678, 0, 4'h0, 32'h0, 32'h1234_5678);

        // Stores, SH with a delayed ready to exercise request stability
        mem_op("sh", 1'b0, 3'b001, 32'h102, 32'hAAAA_BEEF, 32'h0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        mem_op("sb", 1'b0, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);

        // Misaligned and illegal accesses
        fault_op("lw_mis", 3'b010, 32'h101);
        fault_op("lh_mis", 3'b001, 32'h103);
        fault_op("illegal_f3", 3'b011, 32'h100);
        @(negedge clk);

        // Timeout: ready never comes, request held for exactly 16 BUSY cycles
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd7, 1'b1, 1'b1);
        push_exp(32'h200, 5'd7, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        idle_in();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (u_if.dmem_req !== 1'b1) break;
            cnt++;
            if (cnt == 16) check("to_stall_release", u_if.stall, 0);
            else           check("to_stall_held", u_if.stall, 1);
            @(negedge clk);
        end
        check("to_busy_cycles", cnt, 16);

        // Ready arriving on the last BUSY cycle beats the timeout
        drive(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 5'd7, 1'b1, 1'b1);
        push_exp(32'h204, 5'd7, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge clk);
        idle_in();
        repeat (15) @(negedge clk);
        check("race_req", u_if.dmem_req, 1);
        u_if.dmem_ready = 1'b1;
        u_if.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        u_if.dmem_ready = 1'b0;
        check("race_req_drop", u_if.dmem_req, 0);

        // Reset during BUSY aborts without write-back
        drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h5555_5555, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle_in();
        check("rst_busy_req", u_if.dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_abort_req", u_if.dmem_req, 0);
        check("rst_abort_wb", u_if.wb_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mem_op("sw", 1'b0, 3'b010, 32'h304, 32'h1122_3344, 32'h0, 0, 4'b1111, 32'h1122_3344, 32'h0);
        @(negedge clk);

        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
